// File: rtl/wisc_alu_pkg.sv
// Shared constants and FSM state type for the WISC ALU packed-nibble datapath.
package wisc_alu_pkg;

  localparam int unsigned NIBBLES = 4;
  localparam int unsigned NIB_W   = 4;
  localparam int unsigned DATA_W  = NIBBLES * NIB_W;

  localparam logic [NIB_W-1:0] SAT_POS = 4'h7;
  localparam logic [NIB_W-1:0] SAT_NEG = 4'h8;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } paddsb_state_e;

endpackage

// File: rtl/CLA_4bit.sv
// Existing 4-bit signed carry-lookahead adder/subtractor with signed overflow flags.
module CLA_4bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  input  logic       sub,
  output logic [3:0] Sum,
  output logic       pos_Ovfl,
  output logic       neg_Ovfl
);

  logic [3:0] b_eff;
  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  // Subtraction is A + ~B + 1, so sub doubles as the carry-in.
  assign b_eff = sub ? ~B : B;
  assign g     = A & b_eff;
  assign p     = A ^ b_eff;

  assign c[0] = Cin | sub;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);

  assign Sum = p ^ c;

  assign pos_Ovfl = ~A[3] & ~b_eff[3] &  Sum[3];
  assign neg_Ovfl =  A[3] &  b_eff[3] & ~Sum[3];

endmodule

// File: rtl/paddsb_seq.sv
// Sequential saturating nibble add (PADDSB), one lane per cycle through a shared CLA_4bit.
// Define PADDSB_SUB_EN to also honour the sub input (PSUBSB).
module paddsb_seq
  import wisc_alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic              sub,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] Result,
  output logic [NIBBLES-1:0] sat_mask
);

  paddsb_state_e      state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [DATA_W-1:0]  a_q, a_d;
  logic [DATA_W-1:0]  b_q, b_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic [NIBBLES-1:0] mask_q, mask_d;
  logic               done_q, done_d;
  logic               add_sub;

`ifdef PADDSB_SUB_EN
  logic sub_q, sub_d;
  assign add_sub = sub_q;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign add_sub    = 1'b0;
`endif

  logic [NIB_W-1:0] a_lane, b_lane, sum;
  logic             pos_ovfl, neg_ovfl;
  logic [NIB_W-1:0] lane_val;
  logic             lane_sat;

  assign a_lane = a_q[idx_q*NIB_W +: NIB_W];
  assign b_lane = b_q[idx_q*NIB_W +: NIB_W];

  CLA_4bit u_cla (
    .A        (a_lane),
    .B        (b_lane),
    .Cin      (1'b0),
    .sub      (add_sub),
    .Sum      (sum),
    .pos_Ovfl (pos_ovfl),
    .neg_Ovfl (neg_ovfl)
  );

  // Positive clamp takes priority should both flags ever assert.
  always_comb begin
    lane_val = sum;
    lane_sat = 1'b0;
    if (pos_ovfl) begin
      lane_val = SAT_POS;
      lane_sat = 1'b1;
    end else if (neg_ovfl) begin
      lane_val = SAT_NEG;
      lane_sat = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    mask_d   = mask_q;
    done_d   = 1'b0;
`ifdef PADDSB_SUB_EN
    sub_d    = sub_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d      = A;
          b_d      = B;
`ifdef PADDSB_SUB_EN
          sub_d    = sub;
`endif
          result_d = '0;
          mask_d   = '0;
          idx_d    = '0;
          state_d  = StCalc;
        end
      end
      StCalc: begin
        result_d[idx_q*NIB_W +: NIB_W] = lane_val;
        mask_d[idx_q]                  = lane_sat;
        if (idx_q == 2'd3) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      mask_q   <= '0;
      done_q   <= 1'b0;
`ifdef PADDSB_SUB_EN
      sub_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      mask_q   <= mask_d;
      done_q   <= done_d;
`ifdef PADDSB_SUB_EN
      sub_q    <= sub_d;
`endif
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign Result   = result_q;
  assign sat_mask = mask_q;

endmodule

// File: tb/tb_paddsb_seq.sv
// Self-checking bench for paddsb_seq: directed vectors, collisions, mid-op reset, random ops.
module tb_paddsb_seq;

`ifdef PADDSB_SUB_EN
  localparam bit SubEn = 1'b1;
`else
  localparam bit SubEn = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        sub;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [3:0]  sat_mask;

  int errors = 0;
  int checks = 0;

  paddsb_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .A        (a),
    .B        (b),
    .sub      (sub),
    .busy     (busy),
    .done     (done),
    .Result   (result),
    .sat_mask (sat_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: signed nibble arithmetic clamped to [-8, 7]; returns {mask, result}.
  function automatic logic [19:0] model(input logic [15:0] av, input logic [15:0] bv,
                                        input logic s);
    logic [15:0] res;
    logic [3:0]  m;
    logic [3:0]  nib;
    res = '0;
    m   = '0;
    for (int i = 0; i < 4; i++) begin
      int x, y, r;
      x = int'(av[i*4 +: 4]);
      y = int'(bv[i*4 +: 4]);
      if (x > 7) x -= 16;
      if (y > 7) y -= 16;
      r = (SubEn && s) ? x - y : x + y;
      if (r > 7) begin
        nib  = 4'h7;
        m[i] = 1'b1;
      end else if (r < -8) begin
        nib  = 4'h8;
        m[i] = 1'b1;
      end else begin
        nib = 4'(r);
      end
      res[i*4 +: 4] = nib;
    end
    return {m, res};
  endfunction

  // One operation; with collide set, a second start with other operands hits edge N+2.
  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic s, input bit collide);
    logic [19:0] exp;
    int          done_cnt;
    int          done_at;
    logic [15:0] res_at_done;
    logic [3:0]  mask_at_done;
    exp          = model(av, bv, s);
    done_cnt     = 0;
    done_at      = -1;
    res_at_done  = '0;
    mask_at_done = '0;
    @(negedge clk);
    a = av; b = bv; sub = s; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk({tag, " busy_after_start"}, 16'(busy), 16'd1);
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at      = k;
          res_at_done  = result;
          mask_at_done = sat_mask;
        end
      end
      if (k == 4) chk({tag, " busy_at_n4"}, 16'(busy), 16'd1);
      if (k == 5) chk({tag, " busy_at_n5"}, 16'(busy), 16'd0);
      if (collide && k == 1) begin
        a = ~av; b = ~bv; sub = ~s; start = 1'b1;
      end
      if (collide && k == 2) start = 1'b0;
    end
    chk({tag, " done_count"}, 16'(done_cnt), 16'd1);
    chk({tag, " done_latency"}, 16'(done_at), 16'd4);
    chk({tag, " result"}, res_at_done, exp[15:0]);
    chk({tag, " mask"}, 16'(mask_at_done), 16'(exp[19:16]));
    chk({tag, " result_stable"}, result, exp[15:0]);
  endtask

  initial begin
    logic [19:0] exp;
    int          dcnt;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst result", result, 16'h0000);
    chk("rst mask", 16'(sat_mask), 16'h0);
    chk("rst busy", 16'(busy), 16'd0);
    chk("rst done", 16'(done), 16'd0);
    @(negedge clk) rst_n = 1'b1;
    a = 16'hFFFF; b = 16'hFFFF;
    dcnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1 if (done || busy) dcnt++;
    end
    chk("idle activity", 16'(dcnt), 16'd0);
    chk("idle result", result, 16'h0000);

    // Spec vectors, also cross-checking the model against hand-derived values.
    exp = model(16'h1234, 16'h1111, 1'b0);
    chk("model nosat", exp[15:0], 16'h2345);
    run_op("nosat", 16'h1234, 16'h1111, 1'b0, 1'b0);
    exp = model(16'h7181, 16'h1F8F, 1'b0);
    chk("model mixed", {exp[19:16], exp[15:0]} == {4'b1010, 16'h7080} ? 16'd1 : 16'd0, 16'd1);
    run_op("mixed", 16'h7181, 16'h1F8F, 1'b0, 1'b0);
    run_op("allneg", 16'h8888, 16'hFFFF, 1'b0, 1'b0);
    exp = model(16'h7000, 16'h8000, 1'b1);
    chk("model sub", exp[15:0], SubEn ? 16'h7000 : 16'hF000);
    run_op("sub", 16'h7000, 16'h8000, 1'b1, 1'b0);
    run_op("collide", 16'h1234, 16'h7777, 1'b0, 1'b1);

    // Asynchronous reset just after edge N+2 aborts with no done.
    @(negedge clk);
    a = 16'h3333; b = 16'h2222; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort result", result, 16'h0000);
    chk("abort mask", 16'(sat_mask), 16'h0);
    chk("abort busy", 16'(busy), 16'd0);
    chk("abort done", 16'(done), 16'd0);
    @(negedge clk) rst_n = 1'b1;
    dcnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1 if (done) dcnt++;
    end
    chk("abort no_done", 16'(dcnt), 16'd0);
    run_op("post_abort", 16'h3333, 16'h2222, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      run_op("rand", 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
